hit_collector: RTL and testbench

HIT_COLLECTOR -- requirements
Module: hit_collector

---
 rtl/hit_collector.sv | 170 +++++++++++++++++
 tb/tb_hit_collector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_collector.sv
// hit_collector: turns each rising edge of the expand stage's stop level into
// one candidate hit. The candidate is checked for length, bad ordering and
// back-to-back duplicates. A surviving hit goes into a first-word-fall-through
// FIFO that a ready/valid consumer drains.
module hit_collector #(
    parameter int unsigned DEPTH   = 8,   // FIFO entries, power of two, 2..64
    parameter int unsigned MIN_LEN = 32   // shortest extension kept, in bases
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic [31:0] locationStart,
    input  logic [31:0] locationEnd,
    input  logic        hitReady,
    output logic        hitValid,
    output logic [31:0] hitStart,
    output logic [31:0] hitEnd,
    output logic [31:0] hitLength,
    output logic [6:0]  fifoCount,
    output logic [15:0] dropCount,
    output logic [15:0] rejectCount
);

    localparam int          PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0]  DEPTH_C   = 7'(DEPTH);
    localparam logic [31:0] MIN_LEN_C = 32'(MIN_LEN);
    localparam logic [15:0] SAT_C     = 16'hFFFF;

    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
        logic [31:0] len;
    } hit_t;

    // Registered copy of stop; a candidate forms only when stop=1 and this is 0.
    logic             stop_q, stop_d;

    // Stage 1: the captured candidate, waiting for qualification.
    logic             s1_valid_q, s1_valid_d;
    logic             s1_malformed_q, s1_malformed_d;
    hit_t             s1_hit_q, s1_hit_d;

    // Most recent candidate that passed the length and ordering checks.
    logic             last_valid_q, last_valid_d;
    logic [31:0]      last_start_q, last_start_d;
    logic [31:0]      last_end_q, last_end_d;

    // FIFO control and statistics.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [6:0]       count_q, count_d;
    logic [15:0]      drop_q, drop_d;
    logic [15:0]      reject_q, reject_d;

    hit_t             mem [DEPTH];

    // Qualification and handshake terms.
    logic             candidate;
    logic             too_short;
    logic             checks_ok;
    logic             duplicate;
    logic             qualified;
    logic             rejected;
    logic             pop;
    logic             room;
    logic             push;
    logic             drop;

    // The head of the FIFO is read straight from storage (fall-through).
    assign hitValid    = (count_q != 7'd0);
    assign hitStart    = mem[rd_ptr_q].start_addr;
    assign hitEnd      = mem[rd_ptr_q].end_addr;
    assign hitLength   = mem[rd_ptr_q].len;
    assign fifoCount   = count_q;
    assign dropCount   = drop_q;
    assign rejectCount = reject_q;

    // Next-state logic: edge detect, capture, qualify, push/pop, counters.
    always_comb begin
        // NOTE: every signal gets a default at the top, so no path leaves one
        // unassigned and no latch is inferred.
        stop_d         = stop;
        candidate      = stop & ~stop_q;

        // Capture the addresses every cycle. s1_valid marks the cycle that counts.
        s1_valid_d             = candidate;
        s1_hit_d.start_addr    = locationStart;
        s1_hit_d.end_addr      = locationEnd;
        s1_hit_d.len           = locationEnd - locationStart + 32'd1;
        s1_malformed_d         = (locationEnd < locationStart);

        // A malformed candidate is rejected on its own, whatever length wraps to.
        too_short = (s1_hit_q.len < MIN_LEN_C);
        checks_ok = s1_valid_q & ~s1_malformed_q & ~too_short;
        duplicate = last_valid_q
                    & (s1_hit_q.start_addr == last_start_q)
                    & (s1_hit_q.end_addr == last_end_q);
        qualified = checks_ok & ~duplicate;
        rejected  = s1_valid_q & ~qualified;

        // A pop frees a slot in the same cycle, so a full FIFO still takes a write.
        pop  = hitValid & hitReady;
        room = (count_q < DEPTH_C) | pop;
        push = qualified & room;
        drop = qualified & ~room;

        // Duplicate-filter reference tracks candidates that pass the basic
        // checks, whether or not they reach the FIFO.
        last_valid_d = last_valid_q;
        last_start_d = last_start_q;
        last_end_d   = last_end_q;
        if (checks_ok) begin
            last_valid_d = 1'b1;
            last_start_d = s1_hit_q.start_addr;
            last_end_d   = s1_hit_q.end_addr;
        end

        // Pointers are log2(DEPTH) bits wide, so they wrap naturally.
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + 7'(push) - 7'(pop);

        drop_d   = (drop && drop_q != SAT_C) ? drop_q + 16'd1 : drop_q;
        reject_d = (rejected && reject_q != SAT_C) ? reject_q + 16'd1 : reject_q;
    end

    // State registers with synchronous reset; reset also discards an in-flight candidate.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples its _d value from before the edge.
        if (rst) begin
            stop_q         <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_malformed_q <= 1'b0;
            s1_hit_q       <= '0;
            last_valid_q   <= 1'b0;
            last_start_q   <= '0;
            last_end_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            drop_q         <= '0;
            reject_q       <= '0;
        end else begin
            stop_q         <= stop_d;
            s1_valid_q     <= s1_valid_d;
            s1_malformed_q <= s1_malformed_d;
            s1_hit_q       <= s1_hit_d;
            last_valid_q   <= last_valid_d;
            last_start_q   <= last_start_d;
            last_end_q     <= last_end_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            drop_q         <= drop_d;
            reject_q       <= reject_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; hitValid (count_q != 0)
        // keeps stale entries invisible, and leaving it unreset lets it map
        // onto plain RAM.
        if (push) begin
            mem[wr_ptr_q] <= s1_hit_q;
        end
    end

endmodule

// File: tb/tb_hit_collector.sv
// tb_hit_collector: directed scenarios followed by randomized traffic. Every
// cycle is compared against a transaction-level model that keeps a queue of
// expected hits.
module tb_hit_collector;

    localparam int DEPTH   = 8;
    localparam int MIN_LEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic [31:0] locationStart;
    logic [31:0] locationEnd;
    logic        hitReady;
    logic        hitValid;
    logic [31:0] hitStart;
    logic [31:0] hitEnd;
    logic [31:0] hitLength;
    logic [6:0]  fifoCount;
    logic [15:0] dropCount;
    logic [15:0] rejectCount;

    hit_collector #(.DEPTH(DEPTH), .MIN_LEN(MIN_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .stop          (stop),
        .locationStart (locationStart),
        .locationEnd   (locationEnd),
        .hitReady      (hitReady),
        .hitValid      (hitValid),
        .hitStart      (hitStart),
        .hitEnd        (hitEnd),
        .hitLength     (hitLength),
        .fifoCount     (fifoCount),
        .dropCount     (dropCount),
        .rejectCount   (rejectCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] e;
    } mhit_t;

    // Reference model state
    mhit_t       exp_q[$];
    bit          m_prev_stop;
    bit          m_pend;
    logic [31:0] m_ps, m_pe;
    bit          m_last_v;
    logic [31:0] m_ls, m_le;
    int          m_drop, m_rej;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hits_seen;
    logic [31:0] popped_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of the model. A rising stop creates a pending candidate. One
    // edge later that candidate is judged and the FIFO queue is updated.
    task automatic model_step();
        bit          do_pop, has_room, dup;
        logic [31:0] len;
        if (rst) begin
            exp_q.delete();
            m_prev_stop = 0; m_pend = 0; m_last_v = 0;
            m_drop = 0; m_rej = 0;
            return;
        end
        do_pop   = (exp_q.size() != 0) && hitReady;
        has_room = (exp_q.size() < DEPTH) || do_pop;
        if (do_pop) void'(exp_q.pop_front());
        if (m_pend) begin
            len = m_pe - m_ps + 32'd1;
            if (m_pe < m_ps || len < 32'(MIN_LEN)) begin
                if (m_rej < 65535) m_rej++;
            end else begin
                dup = m_last_v && m_ls == m_ps && m_le == m_pe;
                m_last_v = 1; m_ls = m_ps; m_le = m_pe;
                if (dup) begin
                    if (m_rej < 65535) m_rej++;
                end else if (has_room) exp_q.push_back('{s: m_ps, e: m_pe});
                else if (m_drop < 65535) m_drop++;
            end
        end
        m_pend = stop && !m_prev_stop;
        m_ps = locationStart;
        m_pe = locationEnd;
        m_prev_stop = stop;
    endtask

    task automatic compare_all();
        check("hitValid", 32'(hitValid), 32'(exp_q.size() != 0));
        check("fifoCount", 32'(fifoCount), 32'(exp_q.size()));
        check("dropCount", 32'(dropCount), 32'(m_drop));
        check("rejectCount", 32'(rejectCount), 32'(m_rej));
        if (exp_q.size() != 0) begin
            check("hitStart", hitStart, exp_q[0].s);
            check("hitEnd", hitEnd, exp_q[0].e);
            check("hitLength", hitLength, exp_q[0].e - exp_q[0].s + 32'd1);
        end
    endtask

    // Advance one clock: update the model, count a hit if one is taken at
    // this edge, then sample DUT outputs 1 time unit after the edge.
    task automatic tick();
        if (!rst && hitValid === 1'b1 && hitReady) begin
            hits_seen++;
            popped_q.push_back(hitStart);
        end
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; stop = 1'b0;
        tick(); tick();
        rst = 1'b0;
        hits_seen = 0;
        popped_q.delete();
    endtask

    task automatic pulse(input logic [31:0] s, input logic [31:0] e, input int hold);
        locationStart = s; locationEnd = e; stop = 1'b1;
        repeat (hold) tick();
        stop = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; hitReady = 1'b0;
        locationStart = '0; locationEnd = '0;

        // Reset state
        do_reset();
        check("reset_hitValid", 32'(hitValid), 32'd0);
        check("reset_fifoCount", 32'(fifoCount), 32'd0);

        // One hit after 2 cycles; a held stop yields exactly one hit
        hitReady = 1'b1;
        locationStart = 32'd1000; locationEnd = 32'd1063; stop = 1'b1;
        tick();
        check("lat_n1_hitValid", 32'(hitValid), 32'd0);
        tick();
        check("lat_n2_hitValid", 32'(hitValid), 32'd1);
        check("lat_hitStart", hitStart, 32'd1000);
        check("lat_hitEnd", hitEnd, 32'd1063);
        check("lat_hitLength", hitLength, 32'd64);
        repeat (18) tick();
        stop = 1'b0;
        repeat (3) tick();
        check("held_stop_hits", 32'(hits_seen), 32'd1);

        // Short and malformed candidates are rejected
        do_reset();
        pulse(32'd500, 32'd520, 1);
        repeat (3) tick();
        check("short_reject", 32'(rejectCount), 32'd1);
        check("short_no_hit", 32'(hitValid), 32'd0);
        pulse(32'd600, 32'd590, 1);
        repeat (3) tick();
        check("malformed_reject", 32'(rejectCount), 32'd2);

        // The same hit twice in a row is filtered as a duplicate
        do_reset();
        hitReady = 1'b1;
        pulse(32'd2000, 32'd2100, 2);
        repeat (3) tick();
        pulse(32'd2000, 32'd2100, 2);
        repeat (4) tick();
        check("dup_hits", 32'(hits_seen), 32'd1);
        check("dup_reject", 32'(rejectCount), 32'd1);

        // Overflow: 10 hits into 8 slots, then drain in order
        do_reset();
        hitReady = 1'b0;
        for (int i = 0; i < 10; i++) pulse(32'(3000 + i * 100), 32'(3039 + i * 100), 1);
        repeat (2) tick();
        check("ovf_fifoCount", 32'(fifoCount), 32'd8);
        check("ovf_dropCount", 32'(dropCount), 32'd2);
        hitReady = 1'b1;
        repeat (12) tick();
        check("drain_hits", 32'(popped_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < popped_q.size(); k++)
            check("drain_order", popped_q[k], 32'(3000 + k * 100));
        check("drain_fifoCount", 32'(fifoCount), 32'd0);

        // A full FIFO takes a write when a pop happens in the same cycle
        do_reset();
        hitReady = 1'b0;
        for (int i = 0; i < 8; i++) pulse(32'(5000 + i * 100), 32'(5049 + i * 100), 1);
        tick();
        check("full_fifoCount", 32'(fifoCount), 32'd8);
        locationStart = 32'd9000; locationEnd = 32'd9099; stop = 1'b1;
        tick();
        hitReady = 1'b1;
        tick();
        hitReady = 1'b0; stop = 1'b0;
        tick();
        check("pushpop_fifoCount", 32'(fifoCount), 32'd8);
        check("pushpop_dropCount", 32'(dropCount), 32'd0);

        // Reset right after a stop edge discards the candidate
        do_reset();
        hitReady = 1'b1;
        locationStart = 32'd7000; locationEnd = 32'd7099; stop = 1'b1;
        tick();
        rst = 1'b1; stop = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_inflight_hits", 32'(hits_seen), 32'd0);
        check("rst_inflight_reject", 32'(rejectCount), 32'd0);
        check("rst_inflight_drop", 32'(dropCount), 32'd0);

        // stop still high as reset releases gives one fresh candidate
        rst = 1'b1; stop = 1'b1;
        locationStart = 32'd8000; locationEnd = 32'd8099;
        tick();
        rst = 1'b0; hitReady = 1'b0;
        tick(); tick();
        check("rst_release_hitValid", 32'(hitValid), 32'd1);
        check("rst_release_hitStart", hitStart, 32'd8000);
        stop = 1'b0;
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            hitReady = ($urandom_range(0, 2) != 0);
            if (!stop) begin
                locationStart = 32'($urandom_range(0, 7) * 64);
                case ($urandom_range(0, 3))
                    0: locationEnd = locationStart + 32'd19;
                    1: locationEnd = locationStart + 32'd31;
                    2: locationEnd = locationStart + 32'd30;
                    default: locationEnd = locationStart + 32'd49;
                endcase
                if ($urandom_range(0, 7) == 0) locationEnd = locationStart - 32'd5;
            end
            if ($urandom_range(0, 3) == 0) stop = ~stop;
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
